parity_frame_rx: RTL and testbench



---
 rtl/parity_frame_rx.sv | 150 +++++++++++++++
 tb/tb_parity_frame_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx.sv
// Serial start/7-data/parity frame receiver with a one-entry output buffer.
// Optional saturating parity-error counter enabled by PARITY_RX_ERR_CNT_EN.
module parity_frame_rx #(
   parameter bit ODD_PARITY = 1'b0,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sdi,
   input  logic                 sdi_valid,
   output logic                 sdi_ready,
   output logic [6:0]           d_out,
   output logic                 perr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t     state_q;
   logic [2:0] cnt_q;
   logic [6:0] shift_q;
   logic       par_q;
   logic [6:0] hold_word_q;
   logic       hold_err_q;
   logic [6:0] d_out_q;
   logic       perr_q;
   logic       out_valid_q;
   logic       sdi_ready_q;

   logic accept_s;
   logic err_s;
   logic buf_free_s;

   // Bit acceptance, frame parity verdict and output-buffer availability
   always_comb begin
      accept_s   = sdi_valid & sdi_ready_q;
      err_s      = par_q ^ sdi ^ ODD_PARITY;
      buf_free_s = ~out_valid_q | out_ready;
   end

   // Receive FSM, shift register and output buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         shift_q     <= 7'd0;
         par_q       <= 1'b0;
         hold_word_q <= 7'd0;
         hold_err_q  <= 1'b0;
         d_out_q     <= 7'd0;
         perr_q      <= 1'b0;
         out_valid_q <= 1'b0;
         sdi_ready_q <= 1'b1;
      end else begin
         // A drain clears the buffer unless a load below refills it this cycle
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (accept_s && !sdi) begin
                  state_q <= DATA;
                  cnt_q   <= 3'd0;
                  par_q   <= 1'b0;
               end
            end
            DATA: begin
               if (accept_s) begin
                  shift_q[cnt_q] <= sdi;
                  par_q          <= par_q ^ sdi;
                  cnt_q          <= cnt_q + 3'd1;
                  if (cnt_q == 3'd6) begin
                     state_q <= PAR;
                  end
               end
            end
            PAR: begin
               if (accept_s) begin
                  if (buf_free_s) begin
                     d_out_q     <= shift_q;
                     perr_q      <= err_s;
                     out_valid_q <= 1'b1;
                     state_q     <= IDLE;
                  end else begin
                     hold_word_q <= shift_q;
                     hold_err_q  <= err_s;
                     sdi_ready_q <= 1'b0;
                     state_q     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  d_out_q     <= hold_word_q;
                  perr_q      <= hold_err_q;
                  out_valid_q <= 1'b1;
                  sdi_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               sdi_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign sdi_ready = sdi_ready_q;
   assign d_out     = d_out_q;
   assign perr      = perr_q;
   assign out_valid = out_valid_q;

`ifdef PARITY_RX_ERR_CNT_EN
   logic                 load_err_s;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   // An erroneous frame is counted when it lands in d_out, directly or from HOLD
   always_comb begin
      case (state_q)
         PAR:     load_err_s = accept_s & buf_free_s & err_s;
         HOLD:    load_err_s = out_ready & hold_err_q;
         default: load_err_s = 1'b0;
      endcase
   end

   // Saturating parity-error counter
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else if (load_err_s && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end else begin
         err_cnt_q <= err_cnt_q;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: even/odd parity instances and a 2-bit counter instance
// share one stimulus stream; expected err_count follows PARITY_RX_ERR_CNT_EN.
module tb_parity_frame_rx;

`ifdef PARITY_RX_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sdi = 1'b1;
   logic sdi_valid = 1'b0;
   logic out_ready = 1'b1;

   logic       e_sdi_ready, e_perr, e_out_valid;
   logic [6:0] e_d_out;
   logic [7:0] e_err_count;
   logic       o_sdi_ready, o_perr, o_out_valid;
   logic [6:0] o_d_out;
   logic [7:0] o_err_count;
   logic       s_sdi_ready, s_perr, s_out_valid;
   logic [6:0] s_d_out;
   logic [1:0] s_err_count;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   parity_frame_rx #(.ODD_PARITY(1'b0), .ERR_CNT_W(8)) u_even (
      .clk(clk), .reset(reset), .sdi(sdi), .sdi_valid(sdi_valid), .sdi_ready(e_sdi_ready),
      .d_out(e_d_out), .perr(e_perr), .out_valid(e_out_valid), .out_ready(out_ready),
      .err_count(e_err_count));

   parity_frame_rx #(.ODD_PARITY(1'b1), .ERR_CNT_W(8)) u_odd (
      .clk(clk), .reset(reset), .sdi(sdi), .sdi_valid(sdi_valid), .sdi_ready(o_sdi_ready),
      .d_out(o_d_out), .perr(o_perr), .out_valid(o_out_valid), .out_ready(out_ready),
      .err_count(o_err_count));

   parity_frame_rx #(.ODD_PARITY(1'b0), .ERR_CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .sdi(sdi), .sdi_valid(sdi_valid), .sdi_ready(s_sdi_ready),
      .d_out(s_d_out), .perr(s_perr), .out_valid(s_out_valid), .out_ready(out_ready),
      .err_count(s_err_count));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int gap);
      for (int g = 0; g < gap; g++) begin
         sdi_valid = 1'b0;
         sdi = 1'($urandom);
         step();
      end
      sdi = b;
      sdi_valid = 1'b1;
      step();
      sdi_valid = 1'b0;
      sdi = 1'b1;
   endtask

   task automatic send_body(input logic [6:0] w, input int gap);
      send_bit(1'b0, gap);
      for (int i = 0; i < 7; i++) send_bit(w[i], gap);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      vectors++; if (e_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", e_out_valid); end
      vectors++; if (e_d_out !== 7'h00) begin miscompares++; $display("FAIL reset_dout: got %h want 00", e_d_out); end
      vectors++; if (e_perr !== 1'b0) begin miscompares++; $display("FAIL reset_perr: got %b want 0", e_perr); end
      vectors++; if (e_sdi_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", e_sdi_ready); end
      vectors++; if (e_err_count !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", e_err_count); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send_body(7'h1A, 0);
      send_bit(1'b1, 0);
      vectors++; if (e_out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", e_out_valid); end
      vectors++; if (e_d_out !== 7'h1A) begin miscompares++; $display("FAIL basic_dout: got %h want 1a", e_d_out); end
      vectors++; if (e_perr !== 1'b0) begin miscompares++; $display("FAIL basic_perr: got %b want 0", e_perr); end
      vectors++; if (o_perr !== 1'b1) begin miscompares++; $display("FAIL basic_odd_perr: got %b want 1", o_perr); end
      step();
      vectors++; if (e_out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse: got %b want 0", e_out_valid); end
   endtask

   task automatic test_bad_parity();
      send_body(7'h1A, 0);
      send_bit(1'b0, 0);
      vectors++; if (e_perr !== 1'b1) begin miscompares++; $display("FAIL bad_perr: got %b want 1", e_perr); end
      vectors++; if (e_d_out !== 7'h1A) begin miscompares++; $display("FAIL bad_dout: got %h want 1a", e_d_out); end
      vectors++; if (e_err_count !== (CNT_EN ? 8'd1 : 8'd0)) begin miscompares++; $display("FAIL bad_cnt: got %0d want %0d", e_err_count, CNT_EN ? 1 : 0); end
      vectors++; if (o_perr !== 1'b0) begin miscompares++; $display("FAIL bad_odd_perr: got %b want 0", o_perr); end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send_body(7'h55, 0);
      send_bit(1'b0, 0);
      vectors++; if (e_d_out !== 7'h55 || e_out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_a: got %h/%b want 55/1", e_d_out, e_out_valid); end
      send_body(7'h2A, 0);
      send_bit(1'b1, 0);
      vectors++; if (e_sdi_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready: got %b want 0", e_sdi_ready); end
      step();
      step();
      vectors++; if (e_d_out !== 7'h55 || e_out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_stable: got %h/%b want 55/1", e_d_out, e_out_valid); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++; if (e_d_out !== 7'h2A || e_out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_b: got %h/%b want 2a/1", e_d_out, e_out_valid); end
      vectors++; if (e_sdi_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back: got %b want 1", e_sdi_ready); end
      vectors++; if (e_perr !== 1'b0) begin miscompares++; $display("FAIL bp_b_perr: got %b want 0", e_perr); end
      out_ready = 1'b1;
      step();
      vectors++; if (e_out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", e_out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      send_body(7'h33, 0);
      send_bit(1'b0, 0);
      send_body(7'h4C, 0);
      out_ready = 1'b1;
      send_bit(1'b1, 0);
      out_ready = 1'b0;
      vectors++; if (e_d_out !== 7'h4C || e_out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_load: got %h/%b want 4c/1", e_d_out, e_out_valid); end
      vectors++; if (e_sdi_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b want 1", e_sdi_ready); end
   endtask

   task automatic test_reset_midframe();
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      vectors++; if (e_out_valid !== 1'b0 || e_d_out !== 7'h00) begin miscompares++; $display("FAIL mid_drop: got %h/%b want 00/0", e_d_out, e_out_valid); end
      out_ready = 1'b1;
      send_body(7'h7F, 0);
      vectors++; if (e_out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_early: got %b want 0", e_out_valid); end
      send_bit(1'b1, 0);
      vectors++; if (e_d_out !== 7'h7F || e_out_valid !== 1'b1 || e_perr !== 1'b0) begin miscompares++; $display("FAIL mid_frame: got %h/%b/%b want 7f/1/0", e_d_out, e_out_valid, e_perr); end
      vectors++; if (e_err_count !== 8'd0) begin miscompares++; $display("FAIL mid_cnt: got %0d want 0", e_err_count); end
      step();
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1);
      send_body(7'h1A, 2);
      send_bit(1'b1, 3);
      vectors++; if (e_d_out !== 7'h1A || e_out_valid !== 1'b1 || e_perr !== 1'b0) begin miscompares++; $display("FAIL gap_frame: got %h/%b/%b want 1a/1/0", e_d_out, e_out_valid, e_perr); end
      step();
      send_body(7'h00, 1);
      send_bit(1'b1, 1);
      vectors++; if (o_d_out !== 7'h00 || o_out_valid !== 1'b1 || o_perr !== 1'b0) begin miscompares++; $display("FAIL odd_zero: got %h/%b/%b want 00/1/0", o_d_out, o_out_valid, o_perr); end
      vectors++; if (e_perr !== 1'b1) begin miscompares++; $display("FAIL even_zero: got %b want 1", e_perr); end
      step();
   endtask

   task automatic test_saturation();
      logic [1:0] want_s;
      reset = 1'b1;
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         send_body(7'h00, 0);
         send_bit(1'b1, 0);
         want_s = CNT_EN ? ((k > 3) ? 2'd3 : 2'(k)) : 2'd0;
         vectors++; if (s_err_count !== want_s) begin miscompares++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, s_err_count, want_s); end
         vectors++; if (e_err_count !== (CNT_EN ? 8'(k) : 8'd0)) begin miscompares++; $display("FAIL cnt8_%0d: got %0d want %0d", k, e_err_count, CNT_EN ? k : 0); end
         step();
      end
      vectors++; if (o_err_count !== 8'd0) begin miscompares++; $display("FAIL odd_cnt: got %0d want 0", o_err_count); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      test_reset();
      test_basic();
      test_bad_parity();
      test_backpressure();
      test_back_to_back();
      test_reset_midframe();
      test_gaps();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
